// File: rtl/recibir_respuesta_pkg.sv
`default_nettype none
//==============================================================================
// Package     : com_pkg
// Description : Shared constants for the UART command/response path: baud
//               divisors for a 50 MHz clock, line-protocol characters, FSM
//               state encodings and a character-class helper.
// Revision    : 1.0 - initial release
//==============================================================================
package com_pkg;

  // Clock cycles per bit at 50 MHz
  localparam int B115200 = 434;
  localparam int B57600  = 868;
  localparam int B38400  = 1302;
  localparam int B19200  = 2604;
  localparam int B9600   = 5208;
  localparam int B4800   = 10417;
  localparam int B2400   = 20833;
  localparam int B1200   = 41667;
  localparam int B600    = 83333;
  localparam int B300    = 166667;

  // Line-protocol characters
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_0    = 8'h30;

  // Line parser states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISCARD  = 2'd2,
    CLASSIFY = 2'd3
  } parser_state_t;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    START   = 2'd1,
    DATA    = 2'd2,
    STOP    = 2'd3
  } rx_state_t;

  // Visible ASCII range, space through tilde
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage
`default_nettype wire

// File: rtl/recibir_respuesta_if.sv
`default_nettype none
//==============================================================================
// Interface   : recibir_respuesta_if
// Description : Serial input, arm request and result signals between the
//               control side (master) and the response receiver (slave).
// Revision    : 1.0 - initial release
//==============================================================================
interface recibir_respuesta_if;
  logic       rx;
  logic       arm;
  logic       busy_r;
  logic       resp_ok;
  logic       resp_err;
  logic       cmd_valid;
  logic [7:0] cmd_out;
  logic       timeout;
  logic       overflow;

  modport master (
    output rx, arm,
    input  busy_r, resp_ok, resp_err, cmd_valid, cmd_out, timeout, overflow
  );

  modport slave (
    input  rx, arm,
    output busy_r, resp_ok, resp_err, cmd_valid, cmd_out, timeout, overflow
  );
endinterface
`default_nettype wire

// File: rtl/recibir_respuesta_uart_rx.sv
`default_nettype none
//==============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver with a 2-FF input synchroniser. Emits a
//               one-cycle valid with the byte at the stop-bit sample; frames
//               with a low stop bit are dropped.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_rx #(
  parameter int BAUD = 434
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       rx,
  output logic [7:0]      data,
  output logic            valid
);
  import com_pkg::*;

  localparam int               CNT_W  = (BAUD > 2) ? $clog2(BAUD) : 1;
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD - 1);

  logic             r_sync1, r_sync2, r_rx_d;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;

  // Bring rx into the clk domain; r_rx_d holds the previous synchronised value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Frame sequencing: mid-start check, eight LSB-first samples, stop check
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (r_rx_d && !r_sync2) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_sync2 ? RX_IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync2) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/recibir_respuesta.sv
`default_nettype none
//==============================================================================
// Module      : recibir_respuesta
// Description : Assembles CR/LF-terminated lines from the serial receiver and
//               classifies them as OK, ERROR or a #d command digit, with an
//               idle timeout while armed and a sticky line-overflow flag.
// Revision    : 1.0 - initial release
//==============================================================================
module recibir_respuesta #(
  parameter int BAUD     = 434,
  parameter int LINE_MAX = 16,
  parameter int TIMEOUT  = 25000000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  recibir_respuesta_if.slave  bus
);
  import com_pkg::*;

  localparam int                LEN_W     = $clog2(LINE_MAX + 1);
  localparam int                IDX_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [LEN_W-1:0]  C_LEN_MAX = LEN_W'(LINE_MAX);
  localparam logic [27:0]       C_TIMEOUT = 28'(TIMEOUT);

  logic [7:0]       w_byte;
  logic             w_bv;

  parser_state_t    r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [27:0]      r_timer, w_timer_nxt;
  logic [7:0]       r_buf [LINE_MAX];
  logic             w_store;
  logic             r_overflow, w_overflow_nxt;
  logic [7:0]       r_cmd, w_cmd_nxt;
  logic             r_ok, w_ok;
  logic             r_err, w_err;
  logic             r_cmdv, w_cmdv;
  logic             r_timeout, w_timeout;

  uart_rx #(.BAUD(BAUD)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rx    (bus.rx),
    .data  (w_byte),
    .valid (w_bv)
  );

  // Parser state, timer and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_timer    <= '0;
      r_overflow <= 1'b0;
      r_cmd      <= '0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_cmdv     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_timer    <= w_timer_nxt;
      r_overflow <= w_overflow_nxt;
      r_cmd      <= w_cmd_nxt;
      r_ok       <= w_ok;
      r_err      <= w_err;
      r_cmdv     <= w_cmdv;
      r_timeout  <= w_timeout;
    end
  end

  // Line buffer write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINE_MAX; i++) r_buf[i] <= '0;
    end else if (w_store) begin
      r_buf[r_len[IDX_W-1:0]] <= w_byte;
    end
  end

  // Next-state logic; arm overrides everything, a received byte beats expiry
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_timer_nxt    = r_timer;
    w_store        = 1'b0;
    w_overflow_nxt = r_overflow;
    w_cmd_nxt      = r_cmd;
    w_ok           = 1'b0;
    w_err          = 1'b0;
    w_cmdv         = 1'b0;
    w_timeout      = 1'b0;
    if (bus.arm) begin
      w_state_nxt    = COLLECT;
      w_len_nxt      = '0;
      w_timer_nxt    = C_TIMEOUT;
      w_overflow_nxt = 1'b0;
    end else if (r_state != IDLE) begin
      if (w_bv)                 w_timer_nxt = C_TIMEOUT;
      else if (r_timer != '0)   w_timer_nxt = r_timer - 28'd1;
      case (r_state)
        COLLECT: begin
          if (w_bv) begin
            if (w_byte == CH_LF) begin
              if (r_len != '0) w_state_nxt = CLASSIFY;
            end else if (w_byte != CH_CR && is_printable(w_byte)) begin
              if (r_len < C_LEN_MAX) begin
                w_store   = 1'b1;
                w_len_nxt = r_len + LEN_W'(1);
              end else begin
                w_overflow_nxt = 1'b1;
                w_state_nxt    = DISCARD;
              end
            end
          end else if (r_timer == '0) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        DISCARD: begin
          if (w_bv) begin
            if (w_byte == CH_LF) begin
              w_state_nxt = COLLECT;
              w_len_nxt   = '0;
            end
          end else if (r_timer == '0) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        CLASSIFY: begin
          w_state_nxt = IDLE;
          if (r_len == LEN_W'(2) && r_buf[0] == "O" && r_buf[1] == "K") begin
            w_ok = 1'b1;
          end else if (r_len == LEN_W'(5) && r_buf[0] == "E" && r_buf[1] == "R" &&
                       r_buf[2] == "R" && r_buf[3] == "O" && r_buf[4] == "R") begin
            w_err = 1'b1;
          end else if (r_len == LEN_W'(2) && r_buf[0] == CH_HASH &&
                       r_buf[1] >= CH_0 && r_buf[1] <= (CH_0 + 8'd9)) begin
            w_cmdv    = 1'b1;
            w_cmd_nxt = r_buf[1] - CH_0;
          end else begin
            w_state_nxt = COLLECT;
            w_len_nxt   = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.busy_r    = (r_state != IDLE);
  assign bus.resp_ok   = r_ok;
  assign bus.resp_err  = r_err;
  assign bus.cmd_valid = r_cmdv;
  assign bus.cmd_out   = r_cmd;
  assign bus.timeout   = r_timeout;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_recibir_respuesta.sv
`default_nettype none
//==============================================================================
// Module      : tb_recibir_respuesta
// Description : Directed self-checking bench for the response receiver.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_recibir_respuesta;

  localparam int BAUD     = 16;
  localparam int LINE_MAX = 16;
  localparam int TIMEOUT  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  recibir_respuesta_if bus_if ();

  recibir_respuesta #(.BAUD(BAUD), .LINE_MAX(LINE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ok_cnt = 0, err_cnt = 0, cmd_cnt = 0, to_cnt = 0;
  int lf_cyc = 0, ok_cyc = 0;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.u_rx.valid && dut.u_rx.data == 8'h0A) lf_cyc = cyc;
    if (bus_if.resp_ok) begin ok_cnt = ok_cnt + 1; ok_cyc = cyc; end
    if (bus_if.resp_err) err_cnt = err_cnt + 1;
    if (bus_if.cmd_valid) cmd_cnt = cmd_cnt + 1;
    if (bus_if.timeout) to_cnt = to_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) bus_if.rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    bus_if.rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    bus_if.rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_crlf();
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic do_arm();
    @(negedge clk) bus_if.arm = 1'b1;
    @(negedge clk) bus_if.arm = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    repeat (3) @(negedge clk);
    obs = {bus_if.busy_r, bus_if.resp_ok, bus_if.resp_err, bus_if.cmd_valid,
           bus_if.timeout, bus_if.overflow, bus_if.cmd_out};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000", obs);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ok();
    int b_ok, b_err, b_cmd, b_to;
    b_ok = ok_cnt; b_err = err_cnt; b_cmd = cmd_cnt; b_to = to_cnt;
    do_arm();
    checks++;
    if (bus_if.busy_r !== 1'b1) begin
      errors++; $display("FAIL ok_busy_armed: got %b expected 1", bus_if.busy_r);
    end
    send_str("OK");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (ok_cnt - b_ok !== 1) begin
      errors++; $display("FAIL ok_count: got %0d expected 1", ok_cnt - b_ok);
    end
    checks++;
    if ({err_cnt - b_err, cmd_cnt - b_cmd, to_cnt - b_to} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL ok_other_pulses: err %0d cmd %0d to %0d expected 0 0 0",
                         err_cnt - b_err, cmd_cnt - b_cmd, to_cnt - b_to);
    end
    checks++;
    if (ok_cyc - lf_cyc !== 2) begin
      errors++; $display("FAIL ok_latency: got %0d expected 2", ok_cyc - lf_cyc);
    end
    checks++;
    if (bus_if.busy_r !== 1'b0) begin
      errors++; $display("FAIL ok_busy_done: got %b expected 0", bus_if.busy_r);
    end
  endtask

  task automatic test_cmd();
    int b_cmd;
    b_cmd = cmd_cnt;
    do_arm();
    send_str("#7");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_cnt - b_cmd !== 1) begin
      errors++; $display("FAIL cmd7_count: got %0d expected 1", cmd_cnt - b_cmd);
    end
    checks++;
    if (bus_if.cmd_out !== 8'd7) begin
      errors++; $display("FAIL cmd7_value: got %0d expected 7", bus_if.cmd_out);
    end
    do_arm();
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.cmd_out !== 8'd7) begin
      errors++; $display("FAIL cmd_hold: got %0d expected 7", bus_if.cmd_out);
    end
    send_str("#3");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_cnt - b_cmd !== 2) begin
      errors++; $display("FAIL cmd3_count: got %0d expected 2", cmd_cnt - b_cmd);
    end
    checks++;
    if (bus_if.cmd_out !== 8'd3) begin
      errors++; $display("FAIL cmd3_value: got %0d expected 3", bus_if.cmd_out);
    end
  endtask

  task automatic test_lines();
    int b_ok, b_err, b_cmd;
    b_ok = ok_cnt; b_err = err_cnt; b_cmd = cmd_cnt;
    do_arm();
    send_crlf();
    send_str("+CSQ: 9");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if ((ok_cnt - b_ok) + (err_cnt - b_err) + (cmd_cnt - b_cmd) !== 0) begin
      errors++; $display("FAIL lines_no_pulse: got %0d pulses expected 0",
                         (ok_cnt - b_ok) + (err_cnt - b_err) + (cmd_cnt - b_cmd));
    end
    checks++;
    if (bus_if.busy_r !== 1'b1) begin
      errors++; $display("FAIL lines_still_busy: got %b expected 1", bus_if.busy_r);
    end
    send_str("ERROR");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - b_err !== 1) begin
      errors++; $display("FAIL lines_err_count: got %0d expected 1", err_cnt - b_err);
    end
    checks++;
    if (bus_if.busy_r !== 1'b0) begin
      errors++; $display("FAIL lines_busy_done: got %b expected 0", bus_if.busy_r);
    end
  endtask

  task automatic test_overflow();
    int b_ok, b_err, b_cmd;
    b_ok = ok_cnt; b_err = err_cnt; b_cmd = cmd_cnt;
    do_arm();
    for (int i = 0; i < 20; i++) send_byte("A", 1'b1);
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (bus_if.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", bus_if.overflow);
    end
    checks++;
    if ((ok_cnt - b_ok) + (err_cnt - b_err) + (cmd_cnt - b_cmd) !== 0) begin
      errors++; $display("FAIL ovf_no_pulse: got %0d pulses expected 0",
                         (ok_cnt - b_ok) + (err_cnt - b_err) + (cmd_cnt - b_cmd));
    end
    send_str("OK");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (ok_cnt - b_ok !== 1) begin
      errors++; $display("FAIL ovf_ok_count: got %0d expected 1", ok_cnt - b_ok);
    end
    checks++;
    if (bus_if.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", bus_if.overflow);
    end
    do_arm();
    checks++;
    if (bus_if.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_cleared: got %b expected 0", bus_if.overflow);
    end
  endtask

  task automatic test_framing();
    int b_ok;
    b_ok = ok_cnt;
    do_arm();
    send_byte("O", 1'b0);
    send_str("OK");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (ok_cnt - b_ok !== 1) begin
      errors++; $display("FAIL framing_ok_count: got %0d expected 1", ok_cnt - b_ok);
    end
  endtask

  task automatic test_timeout();
    int first, b_to;
    logic busy_before, busy_at;
    first = 0; busy_before = 1'b0; busy_at = 1'b1;
    b_to = to_cnt;
    bus_if.rx = 1'b1;
    do_arm();
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (i == 1000) busy_before = bus_if.busy_r;
      if (bus_if.timeout && first == 0) begin
        first = i;
        busy_at = bus_if.busy_r;
      end
    end
    checks++;
    if (first !== 1001) begin
      errors++; $display("FAIL timeout_cycle: got %0d expected 1001", first);
    end
    checks++;
    if ({busy_before, busy_at} !== 2'b10) begin
      errors++; $display("FAIL timeout_busy: got %b%b expected 10", busy_before, busy_at);
    end
    checks++;
    if (to_cnt - b_to !== 1) begin
      errors++; $display("FAIL timeout_count: got %0d expected 1", to_cnt - b_to);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] obs;
    int b_cmd;
    do_arm();
    @(negedge clk) bus_if.rx = 1'b0;
    repeat (BAUD * 3) @(negedge clk);
    rst = 1'b0;
    #1;
    obs = {bus_if.busy_r, bus_if.resp_ok, bus_if.resp_err, bus_if.cmd_valid,
           bus_if.timeout, bus_if.overflow, bus_if.cmd_out};
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0000", obs);
    end
    @(negedge clk) bus_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (BAUD * 2) @(negedge clk);
    b_cmd = cmd_cnt;
    do_arm();
    send_str("#5");
    send_crlf();
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_cnt - b_cmd !== 1) begin
      errors++; $display("FAIL reset_mid_cmd_count: got %0d expected 1", cmd_cnt - b_cmd);
    end
    checks++;
    if (bus_if.cmd_out !== 8'd5) begin
      errors++; $display("FAIL reset_mid_cmd_value: got %0d expected 5", bus_if.cmd_out);
    end
  endtask

  initial begin
    bus_if.rx  = 1'b1;
    bus_if.arm = 1'b0;
    test_reset();
    test_ok();
    test_cmd();
    test_lines();
    test_overflow();
    test_framing();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/recibir_respuesta.md
# recibir_respuesta

Receive-side counterpart to the command-sending UART sequencer. It deserialises bytes from the serial module's TX line and assembles them into CR/LF-terminated lines. Each line is classified as `OK`, `ERROR` or a `#d` command digit. Results go to the control FSM as single-cycle pulses, and `cmd_out` drives the sender's `comm_in`.

## Interface
- `BAUD`, default 434: clock cycles per bit (50 MHz, 115200 baud).
- `LINE_MAX`, default 16: maximum characters per line, excluding CR/LF.
- `TIMEOUT`, default 25000000: idle cycles allowed while armed.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `arm`  in  1  one-cycle pulse; clears the line buffer and starts listening.
- `busy_r`  out  1  high while armed.
- `resp_ok`  out  1  one-cycle pulse when an `OK` line is received.
- `resp_err`  out  1  one-cycle pulse when an `ERROR` line is received.
- `cmd_valid`  out  1  one-cycle pulse when a `#d` line is received.
- `cmd_out`  out  8  binary digit value 0..9; holds its value until the next `cmd_valid`.
- `timeout`  out  1  one-cycle pulse when the armed window expires.
- `overflow`  out  1  sticky flag for a line longer than `LINE_MAX`; cleared by `arm`.

## Operation
- Reset value of every output is 0; FSM returns to IDLE.
- `rx` passes through a 2-FF synchroniser.
- **Receiver sub-FSM**
  - States RX_IDLE, START, DATA, STOP.
  - A falling edge in RX_IDLE enters START.
  - After `BAUD/2` cycles, `rx` is re-checked; if it is high (glitch), return to RX_IDLE.
  - Otherwise sample 8 bits, one every `BAUD` cycles, LSB first.
  - At the stop-bit sample: if the stop bit is 1, `byte_valid` pulses; if it is 0 (framing error), the byte is dropped.
  - The receiver runs even when not armed.
- **Parser FSM**
  - States IDLE, COLLECT, DISCARD, CLASSIFY.
  - IDLE: bytes are ignored; `arm` enters COLLECT with `len=0` and the timer loaded to `TIMEOUT`.
  - COLLECT, printable byte: if `len<LINE_MAX`, store at `buf[len]` and increment `len`. Otherwise set `overflow` and go to DISCARD.
  - COLLECT, CR (0x0D): ignored.
  - COLLECT, LF (0x0A) with `len=0`: ignored (blank line).
  - COLLECT, LF with `len>0`: go to CLASSIFY.
  - DISCARD: drop every byte until LF, then return to COLLECT with `len=0`.
  - CLASSIFY is one cycle:
    - `len=2`, "OK" → `resp_ok`.
    - `len=5`, "ERROR" → `resp_err`.
    - `len=2`, `buf[0]='#'` and `buf[1]` in '0'..'9' → `cmd_out=buf[1]-0x30`, `cmd_valid`.
    - Any response: return to IDLE.
    - Unrecognised line: return to COLLECT with `len=0` and no pulse.
  - Timer: decrements every cycle while armed. It is reloaded on each `byte_valid`. On reaching 0: `timeout` pulses and the FSM returns to IDLE.
  - `busy_r` = state ≠ IDLE.
- **Simultaneous events**
  - `arm` together with `byte_valid`: `arm` wins and the byte is discarded.
  - `arm` while already armed: restart; buffer, timer and `overflow` are cleared.
  - Timer expiry in the same cycle as LF `byte_valid`: the LF wins and the line is classified; no `timeout`.
- Reset mid-byte or mid-line: everything aborts immediately; no pulse is emitted.

## Timing
- `byte_valid` occurs `9.5*BAUD` cycles (±1) after the synchronised start edge.
- A result pulse (`resp_ok`, `resp_err` or `cmd_valid`) occurs exactly 2 cycles after the LF `byte_valid`: one cycle to enter CLASSIFY, one registered output.
- `cmd_out` updates in the same cycle as `cmd_valid`.
- `timeout` occurs `TIMEOUT+1` cycles after the last reload.
- `busy_r` falls in the same cycle as the result or `timeout` pulse.
- Widths:
  - Bit counter: 3 bits.
  - Baud counter: `$clog2(BAUD)`.
  - `len`: `$clog2(LINE_MAX+1)`.
  - Timer: 28 bits.

## Structure
- Shared package `com_pkg`:
  - Baud constants `B115200` … `B300`.
  - Character constants `CH_CR`, `CH_LF`, `CH_HASH`, `CH_0`.
  - Parser state encoding.
- Sub-module `uart_rx`, parameter `BAUD`, ports `clk`, `rst`, `rx`, `data[7:0]`, `valid`. It contains the synchroniser and the receiver sub-FSM.
- The parser and timer live in the top level.

## Test plan
- Arm, send "OK\r\n" → exactly one `resp_ok`, 2 cycles after the LF; `busy_r` then 0; no other pulses.
- Arm, send "#7\r\n" → `cmd_valid` once with `cmd_out=7`; then arm and send "#3\r\n" → `cmd_out=3`.
- Arm, send "\r\n", "+CSQ: 9\r\n", then "ERROR\r\n" → the blank and unknown lines produce no pulse; a single `resp_err` follows.
- Arm, send 20×'A' then "\r\nOK\r\n" → `overflow`=1, and `resp_ok` fires for the second line.
- Send 'O' with stop bit 0, then a valid "OK\r\n" → the framing-error byte is dropped; `resp_ok` fires once.
- Timeout and reset cases:
  - With `TIMEOUT=1000`: arm and keep `rx` idle → `timeout` pulse at cycle 1001; `busy_r` then 0.
  - `rst` asserted during DATA → all outputs 0, and the next frame is received correctly.
